// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and key map for the keypad scanner
package keypad_pkg;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } scan_state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// rtl/keypad_scanner_sync2.sv - 2-flop synchronizer for the row pins, idles high
module sync2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_meta <= 4'b1111;
      r_sync <= 4'b1111;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with single-key latch
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] rows,
  output logic [NUM_COLS-1:0] cols,
  output logic [3:0]          key_code,
  output logic                key_pressed
);

  localparam int TCW = $clog2(SCAN_DIV);
  localparam logic [TCW-1:0] TC_MAX = TCW'(SCAN_DIV - 1);

  logic [3:0]  w_rows_s;
  logic [3:0]  w_low;
  logic        w_one_low;
  logic [1:0]  w_row_idx;
  logic [1:0]  w_ci_next;
  logic        w_tick;

  scan_state_t    r_state;
  logic [TCW-1:0] r_tc;
  logic [1:0]     r_ci;
  logic [1:0]     r_lr;
  logic [3:0]     r_cols;
  logic [3:0]     r_key_code;
  logic           r_key_pressed;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rows),
    .o_q   (w_rows_s)
  );

  // Two or more low rows in one column is ambiguous (ghosting), so only a single low bit counts.
  assign w_low     = ~w_rows_s;
  assign w_one_low = (w_low != 4'b0000) && ((w_low & (w_low - 4'd1)) == 4'b0000);
  assign w_tick    = (r_tc == TC_MAX);
  assign w_ci_next = r_ci + 2'd1;

  always_comb begin
    w_row_idx = 2'd0;
    case (w_low)
      4'b0010: w_row_idx = 2'd1;
      4'b0100: w_row_idx = 2'd2;
      4'b1000: w_row_idx = 2'd3;
      default: w_row_idx = 2'd0;
    endcase
  end

  // tc wraps on every tick and ci only moves on a tick, so each column dwells SCAN_DIV cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= SCAN;
      r_tc          <= '0;
      r_ci          <= 2'd0;
      r_lr          <= 2'd0;
      r_cols        <= 4'b1110;
      r_key_code    <= 4'h0;
      r_key_pressed <= 1'b0;
    end else begin
      r_tc <= w_tick ? '0 : r_tc + 1'b1;
      if (w_tick) begin
        if (r_state == HOLD) begin
          if (w_rows_s[r_lr]) begin
            r_state       <= SCAN;
            r_key_pressed <= 1'b0;
            r_ci          <= w_ci_next;
            r_cols        <= ~(4'b0001 << w_ci_next);
          end
        end else if (w_one_low) begin
          r_state       <= HOLD;
          r_lr          <= w_row_idx;
          r_key_code    <= key_map(w_row_idx, r_ci);
          r_key_pressed <= 1'b1;
        end else begin
          r_state <= SCAN;
          r_ci    <= w_ci_next;
          r_cols  <= ~(4'b0001 << w_ci_next);
        end
      end
    end
  end

  assign cols        = r_cols;
  assign key_code    = r_key_code;
  assign key_pressed = r_key_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner
module tb_keypad_scanner;

  typedef struct {
    logic       kp;
    logic [3:0] code;
    logic [3:0] cols;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_pressed;

  logic [15:0] key_mask = '0;
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic [4:0]  prev_out;

  keypad_scanner #(.SCAN_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .rows        (rows),
    .cols        (cols),
    .key_code    (key_code),
    .key_pressed (key_pressed)
  );

  always #5 clk = ~clk;

  // Passive matrix: a closed switch at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_mask[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (mon_en && ({key_pressed, key_code} !== prev_out)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event actual kp=%b code=%h cols=%b required no change", key_pressed, key_code, cols);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (key_pressed !== e.kp || key_code !== e.code || cols !== e.cols) begin
          errors++;
          $display("FAIL event actual kp=%b code=%h cols=%b required kp=%b code=%h cols=%b",
                   key_pressed, key_code, cols, e.kp, e.code, e.cols);
        end
      end
      prev_out = {key_pressed, key_code};
    end
  end

  task automatic push(input logic kp, input logic [3:0] code, input logic [3:0] c);
    exp_t e;
    e.kp = kp;
    e.code = code;
    e.cols = c;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int lim, input string name);
    for (int i = 0; i < lim && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s actual pending=%0d required pending=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic wait_cols(input logic [3:0] v, input int lim, input string name);
    int i;
    for (i = 0; i < lim && cols !== v; i++) @(negedge clk);
    check4(name, cols, v);
  endtask

  initial begin
    logic [3:0] seq [5];
    logic [3:0] prev_c;
    int cnt;
    int idx;
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110; seq[4] = 4'b1101;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check4("reset_cols", cols, 4'b1110);
    check4("reset_kp", {3'b000, key_pressed}, 4'h0);
    check4("reset_code", key_code, 4'h0);
    reset = 1'b1;

    prev_c = cols;
    cnt = 0;
    idx = 0;
    for (int i = 0; i < 40 && idx < 5; i++) begin
      @(negedge clk);
      if (cols !== prev_c) begin
        check4("scan_order", cols, seq[idx]);
        if (idx > 0) check4("scan_dwell", 4'(cnt), 4'd4);
        idx++;
        cnt = 1;
        prev_c = cols;
      end else begin
        cnt++;
      end
    end
    checks++;
    if (idx < 5) begin
      errors++;
      $display("FAIL scan_timeout actual transitions=%0d required=5", idx);
    end

    prev_out = {key_pressed, key_code};
    mon_en = 1'b1;

    push(1'b1, 4'h5, 4'b1101);
    key_mask[1*4+1] = 1'b1;
    drain(80, "press_5");
    repeat (12) @(negedge clk);
    check4("hold_cols_5", cols, 4'b1101);

    push(1'b0, 4'h5, 4'b1011);
    key_mask = '0;
    drain(40, "release_5");

    push(1'b1, 4'hD, 4'b0111);
    key_mask[3*4+3] = 1'b1;
    drain(80, "press_d");
    push(1'b0, 4'hD, 4'b1110);
    key_mask = '0;
    drain(40, "release_d");

    key_mask[0*4+0] = 1'b1;
    key_mask[1*4+0] = 1'b1;
    wait_cols(4'b1110, 40, "ghost_col0");
    wait_cols(4'b1101, 10, "ghost_advance");
    repeat (20) @(negedge clk);
    check4("ghost_kp", {3'b000, key_pressed}, 4'h0);
    key_mask = '0;
    repeat (4) @(negedge clk);

    push(1'b1, 4'hA, 4'b0111);
    key_mask[0*4+3] = 1'b1;
    drain(80, "press_a");
    push(1'b0, 4'h0, 4'b1110);
    push(1'b1, 4'hA, 4'b0111);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drain(80, "reset_hold_redetect");
    push(1'b0, 4'hA, 4'b1110);
    key_mask = '0;
    drain(40, "release_a");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Drives the columns of a 4x4 matrix keypad and samples its rows to find a single pressed key. Produces the raw 4-bit hex key code and a `key_pressed` level that feed the keypad debouncer downstream. The scanner is the initiator side of the keypad interface. It does no bounce filtering; the debouncer owns that.

## Interface
- `SCAN_DIV`, default 4: clock cycles each column is driven before its rows are sampled. Legal range is ≥ 3 (covers 2 sync cycles plus settling).
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-low; clock clk.
- `rows` in 4: keypad row pins, active-low (pulled up), asynchronous to `clk`.
- `cols` out 4: keypad column drive, one-hot-low.
- `key_code` out 4: hex code of the latched key. It holds its last value after release.
- `key_pressed` out 1: high while the latched key is held.

## Operation
**Input synchronisation**
- `rows` passes through a 2-flop synchronizer, reset value 4'b1111. All decisions use the synchronized value `rows_s`.

**Column scanning**
- Column index `ci` counts 0..3, and `cols = ~(4'b0001 << ci)`.
- Tick counter `tc` counts 0..SCAN_DIV-1 and is free-running. `tick` is asserted when `tc == SCAN_DIV-1`.
- `tc` clears whenever `ci` changes, so every column dwells exactly SCAN_DIV cycles.

**Key map (row r, col c → code)**
- r0: 1, 2, 3, A
- r1: 4, 5, 6, B
- r2: 7, 8, 9, C
- r3: E, 0, F, D

**FSM states: SCAN, HOLD**
- SCAN:
  - On `tick`, if `rows_s` has exactly one low bit r: go to HOLD. Latch r into `lr`, load `key_code = map(r, ci)`, set `key_pressed = 1`. `ci` is frozen.
  - On `tick`, if `rows_s` is 1111 or has two or more low bits: stay in SCAN and advance `ci` (3 wraps to 0).
  - When there is no tick: hold all state.
- HOLD:
  - `cols` stays frozen on the pressed key's column.
  - On `tick`, if `rows_s[lr]` is 1: go to SCAN, clear `key_pressed`, advance `ci`. `key_code` is unchanged.
  - Otherwise stay in HOLD. Other rows going low while in HOLD are ignored.
  - Keys in other columns are never seen while in HOLD. There is no rollover.
- Default or illegal state decodes to SCAN.

**Reset values**
- State is SCAN, `ci` = 0, `cols` = 4'b1110, `tc` = 0, `rows_s` = 4'b1111, `key_pressed` = 0, `key_code` = 4'h0.
- A reset asserted mid-HOLD returns every register to these values at the next edge.

## Timing
- All outputs are registered and change only on `clk` rising edges.
- `key_code` and `key_pressed` update on the same edge: the one after the detecting `tick` cycle.
- Pin-to-output latency from a row going low is 2 sync cycles plus up to 4·SCAN_DIV cycles to reach that column, plus 1 cycle.
- Release latency is 2 sync cycles, plus up to SCAN_DIV cycles to the next tick, plus 1 cycle.
- `cols` changes on the same edge as the state or `ci` update. Rows are never sampled before SCAN_DIV-1 cycles after a column change.
- A bounce during HOLD that is high at a tick counts as a release. The next press is re-detected on a later scan pass, and the debouncer filters it.

## Structure
- Package `keypad_pkg` holds:
  - the FSM state enum `scan_state_t` (SCAN, HOLD);
  - the `NUM_ROWS` and `NUM_COLS` = 4 constants;
  - the key-map function `key_map(row, col)`, which the debouncer-side testbench also uses.
- Sub-module `sync2`: a 2-flop synchronizer, 4 bits wide, with reset value 1111.
- The scanner holds the counter, column index, FSM and output registers.

## Test plan
- **Reset and idle scan.** Hold `reset` = 0 for 3 cycles, then release with `rows` = 1111. Required: `cols` = 1110, `key_pressed` = 0, `key_code` = 0 during reset. After release, `cols` cycles 1110 → 1101 → 1011 → 0111 → 1110, with each value held exactly 4 cycles.
- **Single press "5".** Drive `rows` = 1101 (r1) only while `cols` = 1101. Required: `key_code` = 5 and `key_pressed` = 1 one cycle after the tick. `cols` stays at 1101 while the row is held.
- **Release.** Return `rows` to 1111 during HOLD. Required: `key_pressed` falls one cycle after the next tick, `cols` moves to 1011, and `key_code` stays 5.
- **Wrap-around key "D".** Assert r3 low while column 3 is driven. Required: `key_code` = 4'hD, `cols` frozen at 0111. After release, `cols` = 1110.
- **Ghost rejection.** Drive `rows` = 1100 while column 0 is driven. Required: no HOLD, `key_pressed` stays 0, and the scan continues to 1101.
- **Reset mid-HOLD.** While holding "A" (r0, c3), pulse `reset` = 0 for 1 cycle. Required: next edge gives `cols` = 1110, `key_pressed` = 0, `key_code` = 0. The key is re-detected on the next pass through column 3.
